// File: rtl/il_ctrl_pkg.sv
// Shared encodings for the task-clock run controller: opcodes, completion
// status codes and the sequencer state encoding.
package il_ctrl_pkg;

    localparam logic [1:0] IL_OP_HALT   = 2'b00;
    localparam logic [1:0] IL_OP_RUN    = 2'b01;
    localparam logic [1:0] IL_OP_STEP   = 2'b10;
    localparam logic [1:0] IL_OP_RUN_TO = 2'b11;

    localparam logic [1:0] IL_ST_DONE    = 2'b00;
    localparam logic [1:0] IL_ST_PREEMPT = 2'b01;
    localparam logic [1:0] IL_ST_PASSED  = 2'b10;
    localparam logic [1:0] IL_ST_EXT     = 2'b11;

    typedef enum logic [1:0] {
        IL_S_HALTED = 2'b00,
        IL_S_FREE   = 2'b01,
        IL_S_COUNT  = 2'b10
    } il_state_e;

endpackage

// File: rtl/il_clk_gate.sv
// Task-clock gate: BUFGCE (I=sys_clk, CE=ce, O=gated_clk) when IL_USE_BUFGCE
// is defined, otherwise a behavioural latch-based glitch-free gate.
module il_clk_gate (
    input  logic sys_clk,
    input  logic ce,
    output logic gated_clk
);

`ifdef IL_USE_BUFGCE
    BUFGCE u_bufgce (
        .I  (sys_clk),
        .CE (ce),
        .O  (gated_clk)
    );
`else
    logic ce_lat;

    // Enable only passes while the clock is low, so it cannot chop a high phase.
    always_latch begin
        if (!sys_clk) begin
            ce_lat <= ce;
        end
    end

    assign gated_clk = sys_clk & ce_lat;
`endif

endmodule

// File: rtl/il_run_controller.sv
// Run-control sequencer driving the task-clock enable and cycle counter.
// Optional external halt input is compiled in with IL_EXT_HALT_EN.
module il_run_controller
    import il_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
`ifdef IL_EXT_HALT_EN
    input  logic             halt_trig,
`endif
    output logic             task_clk,
    output logic             task_clk_en,
    output logic [CNT_W-1:0] cycle_count,
    output logic             busy,
    output logic             done,
    output logic [1:0]       done_status,
    output il_state_e        state_dbg
);

    // Handshake: a command transfers at a sys_clk edge where cmd_valid and
    // cmd_ready are both 1; ready stays high after reset, so every command wins.
    il_state_e        state, state_nx;
    logic [CNT_W-1:0] rem, rem_nx;
    logic [CNT_W-1:0] run_len;
    logic             en_nx, done_nx;
    logic [1:0]       status_nx;
    logic             accept;
    logic             ext_halt;

`ifdef IL_EXT_HALT_EN
    assign ext_halt = halt_trig;
`else
    assign ext_halt = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state       <= IL_S_HALTED;
            rem         <= '0;
            task_clk_en <= 1'b0;
            done        <= 1'b0;
            done_status <= IL_ST_DONE;
            cmd_ready   <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_nx;
            rem         <= rem_nx;
            task_clk_en <= en_nx;
            done        <= done_nx;
            done_status <= status_nx;
            cmd_ready   <= 1'b1;
            if (task_clk_en) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

    // RUN_TO is turned into a STEP of the remaining distance to the target.
    assign run_len = (cmd_op == IL_OP_STEP) ? cmd_arg : (cmd_arg - cycle_count);

    always_comb begin
        state_nx  = state;
        rem_nx    = rem;
        en_nx     = task_clk_en;
        done_nx   = 1'b0;
        status_nx = done_status;
        if (accept) begin
            if (cmd_op == IL_OP_HALT) begin
                state_nx  = IL_S_HALTED;
                rem_nx    = '0;
                en_nx     = 1'b0;
                done_nx   = 1'b1;
                status_nx = busy ? IL_ST_PREEMPT : IL_ST_DONE;
            end else if (ext_halt) begin
                state_nx  = IL_S_HALTED;
                rem_nx    = '0;
                en_nx     = 1'b0;
                done_nx   = 1'b1;
                status_nx = IL_ST_EXT;
            end else if (cmd_op == IL_OP_RUN) begin
                state_nx = IL_S_FREE;
                rem_nx   = '0;
                en_nx    = 1'b1;
                if (busy) begin
                    done_nx   = 1'b1;
                    status_nx = IL_ST_PREEMPT;
                end
            end else if ((cmd_op == IL_OP_RUN_TO) && (cmd_arg < cycle_count)) begin
                state_nx  = IL_S_HALTED;
                rem_nx    = '0;
                en_nx     = 1'b0;
                done_nx   = 1'b1;
                status_nx = IL_ST_PASSED;
            end else if (run_len == '0) begin
                // Zero-length run: a single pulse reports it, even if it preempts.
                state_nx  = IL_S_HALTED;
                rem_nx    = '0;
                en_nx     = 1'b0;
                done_nx   = 1'b1;
                status_nx = IL_ST_DONE;
            end else begin
                state_nx = IL_S_COUNT;
                rem_nx   = run_len;
                en_nx    = 1'b1;
                if (busy) begin
                    done_nx   = 1'b1;
                    status_nx = IL_ST_PREEMPT;
                end
            end
        end else if (ext_halt && busy) begin
            state_nx  = IL_S_HALTED;
            rem_nx    = '0;
            en_nx     = 1'b0;
            done_nx   = 1'b1;
            status_nx = IL_ST_EXT;
        end else if (state == IL_S_COUNT) begin
            if (rem == CNT_W'(1)) begin
                state_nx  = IL_S_HALTED;
                rem_nx    = '0;
                en_nx     = 1'b0;
                done_nx   = 1'b1;
                status_nx = IL_ST_DONE;
            end else begin
                rem_nx = rem - 1'b1;
            end
        end
    end

    always_comb begin
        accept    = cmd_valid & cmd_ready;
        busy      = (state == IL_S_FREE) || (state == IL_S_COUNT);
        state_dbg = state;
    end

    il_clk_gate u_clk_gate (
        .sys_clk   (sys_clk),
        .ce        (task_clk_en),
        .gated_clk (task_clk)
    );

endmodule

// File: tb/tb_il_run_controller.sv
// Directed bench for il_run_controller with an 8-bit counter so wrap is reachable.
// Define IL_EXT_HALT_EN to include the external halt scenarios.
module tb_il_run_controller;
  import il_ctrl_pkg::*;

  localparam int CNT_W = 8;

  logic             sys_clk = 1'b0;
  logic             sys_reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_arg = '0;
  logic             halt_trig = 1'b0;
  logic             task_clk;
  logic             task_clk_en;
  logic [CNT_W-1:0] cycle_count;
  logic             busy;
  logic             done;
  logic [1:0]       done_status;
  il_state_e        state_dbg;

  int total = 0;
  int bad = 0;
  int gclk_edges = 0;
  int n;

  il_run_controller #(.CNT_W(CNT_W)) dut (
    .sys_clk     (sys_clk),
    .sys_reset   (sys_reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
`ifdef IL_EXT_HALT_EN
    .halt_trig   (halt_trig),
`endif
    .task_clk    (task_clk),
    .task_clk_en (task_clk_en),
    .cycle_count (cycle_count),
    .busy        (busy),
    .done        (done),
    .done_status (done_status),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  always @(posedge task_clk) gclk_edges++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] arg);
    int w = 0;
    while (!cmd_ready && w < 10) begin
      tick();
      w++;
    end
    check("cmd_ready_before_send", {31'b0, cmd_ready}, 32'd1);
    cmd_op = op;
    cmd_arg = arg;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic count_enabled(output int cnt);
    cnt = 0;
    while (task_clk_en && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    halt_trig = 1'b0;
    sys_reset = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("rst_en", {31'b0, task_clk_en}, 32'd0);
    check("rst_count", {24'b0, cycle_count}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_status", {30'b0, done_status}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_state", {30'b0, state_dbg}, {30'b0, IL_S_HALTED});
    @(negedge sys_clk);
    sys_reset = 1'b0;
    tick();
    check("rst_ready_rise", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    do_reset();

    // STEP 5 from reset
    gclk_edges = 0;
    send(IL_OP_STEP, 8'd5);
    check("step5_en_after_accept", {31'b0, task_clk_en}, 32'd1);
    check("step5_no_done_at_accept", {31'b0, done}, 32'd0);
    check("step5_busy", {31'b0, busy}, 32'd1);
    count_enabled(n);
    check("step5_enabled_cycles", n, 32'd5);
    check("step5_done", {31'b0, done}, 32'd1);
    check("step5_status", {30'b0, done_status}, {30'b0, IL_ST_DONE});
    check("step5_count", {24'b0, cycle_count}, 32'd5);
    check("step5_gated_edges", gclk_edges, 32'd5);
    tick();
    check("step5_done_one_cycle", {31'b0, done}, 32'd0);

    // RUN_TO 12 from 5, then RUN_TO 3 (passed)
    send(IL_OP_RUN_TO, 8'd12);
    count_enabled(n);
    check("runto12_cycles", n, 32'd7);
    check("runto12_done", {31'b0, done}, 32'd1);
    check("runto12_status", {30'b0, done_status}, {30'b0, IL_ST_DONE});
    check("runto12_count", {24'b0, cycle_count}, 32'd12);
    send(IL_OP_RUN_TO, 8'd3);
    check("runto3_done", {31'b0, done}, 32'd1);
    check("runto3_status", {30'b0, done_status}, {30'b0, IL_ST_PASSED});
    check("runto3_en", {31'b0, task_clk_en}, 32'd0);
    tick();
    check("runto3_count", {24'b0, cycle_count}, 32'd12);

    // zero-length commands and HALT while idle
    send(IL_OP_RUN_TO, 8'd12);
    check("runto_eq_done", {31'b0, done}, 32'd1);
    check("runto_eq_status", {30'b0, done_status}, {30'b0, IL_ST_DONE});
    check("runto_eq_en", {31'b0, task_clk_en}, 32'd0);
    tick();
    send(IL_OP_RUN_TO, 8'd3);
    send(IL_OP_STEP, 8'd0);
    check("step0_done", {31'b0, done}, 32'd1);
    check("step0_status", {30'b0, done_status}, {30'b0, IL_ST_DONE});
    check("step0_en", {31'b0, task_clk_en}, 32'd0);
    tick();
    check("step0_count", {24'b0, cycle_count}, 32'd12);
    send(IL_OP_HALT, 8'd0);
    check("halt_idle_done", {31'b0, done}, 32'd1);
    check("halt_idle_status", {30'b0, done_status}, {30'b0, IL_ST_DONE});

    // RUN 20 cycles then STEP 4 preempts with no enable gap
    do_reset();
    send(IL_OP_RUN, 8'd0);
    check("run_en", {31'b0, task_clk_en}, 32'd1);
    check("run_no_done", {31'b0, done}, 32'd0);
    check("run_state", {30'b0, state_dbg}, {30'b0, IL_S_FREE});
    repeat (19) tick();
    send(IL_OP_STEP, 8'd4);
    check("preempt_done", {31'b0, done}, 32'd1);
    check("preempt_status", {30'b0, done_status}, {30'b0, IL_ST_PREEMPT});
    check("preempt_en_no_gap", {31'b0, task_clk_en}, 32'd1);
    check("preempt_count_at_accept", {24'b0, cycle_count}, 32'd20);
    count_enabled(n);
    check("preempt_step_cycles", n, 32'd4);
    check("preempt_step_status", {30'b0, done_status}, {30'b0, IL_ST_DONE});
    check("preempt_count_final", {24'b0, cycle_count}, 32'd24);

    // reach 250 with RUN + HALT, then STEP 10 wraps to 4
    do_reset();
    send(IL_OP_RUN, 8'd0);
    repeat (249) tick();
    send(IL_OP_HALT, 8'd0);
    check("halt_busy_done", {31'b0, done}, 32'd1);
    check("halt_busy_status", {30'b0, done_status}, {30'b0, IL_ST_PREEMPT});
    check("halt_busy_en", {31'b0, task_clk_en}, 32'd0);
    check("count_250", {24'b0, cycle_count}, 32'd250);
    send(IL_OP_STEP, 8'd10);
    count_enabled(n);
    check("wrap_cycles", n, 32'd10);
    check("wrap_count", {24'b0, cycle_count}, 32'd4);
    check("wrap_status", {30'b0, done_status}, {30'b0, IL_ST_DONE});
    check("wrap_done", {31'b0, done}, 32'd1);

    // asynchronous reset in the middle of STEP 100
    send(IL_OP_STEP, 8'd100);
    repeat (10) tick();
    #3;
    sys_reset = 1'b1;
    #1;
    check("async_rst_en", {31'b0, task_clk_en}, 32'd0);
    check("async_rst_count", {24'b0, cycle_count}, 32'd0);
    check("async_rst_done", {31'b0, done}, 32'd0);
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    repeat (2) tick();
    check("async_rst_still_no_done", {31'b0, done}, 32'd0);
    @(negedge sys_clk);
    sys_reset = 1'b0;
    tick();
    check("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    check("post_rst_en", {31'b0, task_clk_en}, 32'd0);
    check("post_rst_no_done", {31'b0, done}, 32'd0);

`ifdef IL_EXT_HALT_EN
    // external halt while running, then STEP 3 while the halt is held
    do_reset();
    send(IL_OP_RUN, 8'd0);
    repeat (6) tick();
    halt_trig = 1'b1;
    tick();
    check("ext_halt_en", {31'b0, task_clk_en}, 32'd0);
    check("ext_halt_done", {31'b0, done}, 32'd1);
    check("ext_halt_status", {30'b0, done_status}, {30'b0, IL_ST_EXT});
    check("ext_halt_count", {24'b0, cycle_count}, 32'd7);
    check("ext_halt_busy", {31'b0, busy}, 32'd0);
    send(IL_OP_STEP, 8'd3);
    check("ext_step_done", {31'b0, done}, 32'd1);
    check("ext_step_status", {30'b0, done_status}, {30'b0, IL_ST_EXT});
    check("ext_step_en", {31'b0, task_clk_en}, 32'd0);
    halt_trig = 1'b0;
    tick();
    check("ext_step_count", {24'b0, cycle_count}, 32'd7);
    check("ext_step_done_clear", {31'b0, done}, 32'd0);
`endif

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/il_run_controller.md
# il_run_controller

Run-control sequencer for the task clock gate. It accepts debugger commands (halt, free-run, step N cycles, run to an absolute cycle) over a valid/ready port and drives the clock-enable of the gated task clock. It keeps a free-running count of task-clock cycles so state capture can be aligned to an exact cycle. It sits between the debug command source (VIO/JTAG bridge) and the task-clock BUFGCE.

## Interface
- CNT_W, 32: width of cycle counter, step argument and target.
- sys_clk  in  1  system clock; also the ungated source of task_clk.
- sys_reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready at a sys_clk edge.
- cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 RUN_TO.
- cmd_arg  in  CNT_W  STEP: cycle count N; RUN_TO: absolute target; otherwise ignored.
- task_clk  out  1  gated clock; BUFGCE output with CE = task_clk_en.
- task_clk_en  out  1  registered gate enable; also exported for debug.
- cycle_count  out  CNT_W  number of enabled task_clk cycles since reset.
- busy  out  1  state is FREE or COUNT.
- done  out  1  one-cycle completion pulse.
- done_status  out  2  valid with done: 00 complete, 01 preempted/halted, 10 target passed, 11 external halt.
- halt_trig  in  1  external halt level; exists only with IL_EXT_HALT_EN.

## Operation
- FSM states: HALTED, FREE, COUNT. Down-counter rem (CNT_W bits).
- Reset values: state HALTED, task_clk_en 0, cycle_count 0, rem 0, done 0, done_status 00, cmd_ready 0.
- cmd_ready rises at the first sys_clk edge after reset deassertion and then stays 1. Commands are always accepted and preempt any running command.
- HALT: go to HALTED, task_clk_en 0. Done status is 01 if the block was busy, 00 otherwise.
- RUN: go to FREE, task_clk_en 1. No done until preempted or halted.
- STEP N, N>0: go to COUNT with rem=N and task_clk_en 1. STEP 0: done with status 00 on accept; no enabled cycle.
- RUN_TO T, unsigned compare against cycle_count at accept:
  - T>count: behaves exactly like STEP (T-count).
  - T==count: done with status 00 on accept.
  - T<count: done with status 10 on accept; state becomes HALTED.
- COUNT: rem decrements each enabled cycle. When the edge ends the cycle with rem==1: task_clk_en goes to 0, state goes to HALTED, done pulses with status 00.
- Preemption while busy by a non-zero-length run command: done pulses with status 01 and the new command starts. task_clk_en stays 1 with no gap.
- Preemption by a zero-length or rejected command: a single done pulse carries the new command's status.
- cycle_count increments at every edge where task_clk_en==1. It wraps from 2^CNT_W-1 to 0. It is cleared only by sys_reset.

## Timing
- Accept at edge E: task_clk_en is 1 for the cycle after E. STEP N yields exactly N enabled cycles.
- done is registered and asserts at the same edge at which task_clk_en falls.
- Priority at one edge: sys_reset > accepted command > halt_trig > count completion.
- Reset mid-run: task_clk_en drops asynchronously, no done pulse.

## Configuration
- IL_EXT_HALT_EN defined:
  - halt_trig port exists and is sampled synchronously.
  - While halt_trig is 1 in FREE/COUNT: next edge gives HALTED, task_clk_en 0, done status 11.
  - A RUN/STEP/RUN_TO accepted while halt_trig is 1 completes immediately with status 11 and no enabled cycle.
- IL_EXT_HALT_EN undefined: no halt_trig port; all halt logic is removed.

## Structure
- Package il_ctrl_pkg holds:
  - opcode constants (IL_OP_HALT/RUN/STEP/RUN_TO);
  - status constants (IL_ST_DONE/PREEMPT/PASSED/EXT);
  - FSM state encoding.
- One sub-module, il_clk_gate: BUFGCE wrapper, I=sys_clk, CE=task_clk_en, O=task_clk. In simulation it is a behavioural latch-based gate.

## Test plan
- Reset, then STEP 5 -> task_clk_en high exactly 5 cycles starting 1 cycle after accept; cycle_count 5; done with status 00 on the falling edge of task_clk_en.
- cycle_count 5, RUN_TO 12 -> 7 enabled cycles, count 12, status 00. Then RUN_TO 3 -> immediate done, status 10, no enabled cycle.
- RUN, wait 20 cycles, STEP 4 -> done status 01 at accept; task_clk_en continuously high for 4 more cycles; count 24.
- CNT_W=8, count 250, STEP 10 -> count wraps to 4; done status 00.
- sys_reset asserted mid STEP 100 -> task_clk_en 0 asynchronously, count 0, no done.
- With IL_EXT_HALT_EN: RUN, halt_trig high at cycle 7 -> halted next edge, status 11. STEP 3 while halt_trig held -> immediate done status 11.
